// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM states, keypad decode table and default timing shared by
// the keypad digit capture block.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_t;

    localparam int DEFAULT_SCAN_DIV        = 24000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 480000;
    localparam int DEFAULT_REPEAT_CYCLES   = 12000000;

    // Nibble {row,col} holds the legend of that key: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    localparam logic [63:0] KEY_DECODE_TABLE = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
        logic [5:0] base_s;
        base_s = {row, col, 2'b00};
        return KEY_DECODE_TABLE[base_s +: 4];
    endfunction

    // Returns {valid, row index}; valid only when exactly one row is pulled low
    function automatic logic [2:0] single_low_row(input logic [3:0] rows);
        case (rows)
            4'b1110: return 3'b100;
            4'b1101: return 3'b101;
            4'b1011: return 3'b110;
            4'b0111: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/keypad_sync2.sv
// keypad_sync2: 4-bit two-flop synchronizer for the asynchronous keypad rows.
// Idle value is all ones (no row pulled low).
module keypad_sync2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_r;
    logic [3:0] sync_r;

    // Two-stage capture of the row lines
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_r <= 4'hF;
            sync_r <= 4'hF;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_digit_capture.sv
// keypad_digit_capture: scans a 4x4 keypad, debounces press/release and shifts
// accepted digits into s0/s1. Define KEYPAD_AUTOREPEAT_EN to repeat a held key.
module keypad_digit_capture
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = DEFAULT_SCAN_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic       key_valid
);

    localparam int SCAN_W = cnt_width(SCAN_DIV);
    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);

    logic [3:0]        rows_s;
    logic [2:0]        row_hit_s;
    key_state_t        state_r;
    logic [3:0]        cols_r;
    logic [1:0]        col_idx_r;
    logic [1:0]        row_idx_r;
    logic [3:0]        row_pat_r;
    logic [SCAN_W-1:0] scan_cnt_r;
    logic [DB_W-1:0]   db_cnt_r;
    logic [3:0]        s0_r;
    logic [3:0]        s1_r;
    logic              key_valid_r;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = cnt_width(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
    logic [REP_W-1:0] rep_cnt_r;
`else
    // Repeat period has no effect when auto-repeat is compiled out
    logic [31:0] repeat_unused_s;
    assign repeat_unused_s = 32'(REPEAT_CYCLES);
`endif

    keypad_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_s)
    );

    assign row_hit_s = single_low_row(rows_s);

    // Scan / debounce / hold FSM with registered column drive and digit outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= SCAN;
            cols_r      <= 4'b1110;
            col_idx_r   <= 2'd0;
            row_idx_r   <= 2'd0;
            row_pat_r   <= 4'hF;
            scan_cnt_r  <= {SCAN_W{1'b0}};
            db_cnt_r    <= {DB_W{1'b0}};
            s0_r        <= 4'h0;
            s1_r        <= 4'h0;
            key_valid_r <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_r   <= {REP_W{1'b0}};
`endif
        end else begin
            key_valid_r <= 1'b0;
            case (state_r)
                SCAN: begin
                    if (scan_cnt_r == SCAN_LAST) begin
                        scan_cnt_r <= {SCAN_W{1'b0}};
                        if (row_hit_s[2]) begin
                            row_idx_r <= row_hit_s[1:0];
                            row_pat_r <= rows_s;
                            db_cnt_r  <= {DB_W{1'b0}};
                            state_r   <= PRESS_DB;
                        end else begin
                            cols_r    <= {cols_r[2:0], cols_r[3]};
                            col_idx_r <= col_idx_r + 2'd1;
                        end
                    end else begin
                        scan_cnt_r <= scan_cnt_r + SCAN_ONE;
                    end
                end
                PRESS_DB: begin
                    if (rows_s != row_pat_r) begin
                        scan_cnt_r <= {SCAN_W{1'b0}};
                        cols_r     <= {cols_r[2:0], cols_r[3]};
                        col_idx_r  <= col_idx_r + 2'd1;
                        state_r    <= SCAN;
                    end else if (db_cnt_r == DB_LAST) begin
                        s1_r        <= s0_r;
                        s0_r        <= key_decode(row_idx_r, col_idx_r);
                        key_valid_r <= 1'b1;
                        state_r     <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt_r   <= {REP_W{1'b0}};
`endif
                    end else begin
                        db_cnt_r <= db_cnt_r + DB_ONE;
                    end
                end
                HELD: begin
                    // Only a full release matters here; extra keys are ignored
                    if (rows_s == 4'hF) begin
                        db_cnt_r <= {DB_W{1'b0}};
                        state_r  <= RELEASE_DB;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_cnt_r == REP_LAST) begin
                        rep_cnt_r   <= {REP_W{1'b0}};
                        s1_r        <= s0_r;
                        s0_r        <= key_decode(row_idx_r, col_idx_r);
                        key_valid_r <= 1'b1;
                    end else begin
                        rep_cnt_r <= rep_cnt_r + REP_ONE;
                    end
`else
                    else begin
                        state_r <= HELD;
                    end
`endif
                end
                RELEASE_DB: begin
                    if (rows_s != 4'hF) begin
                        state_r   <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt_r <= {REP_W{1'b0}};
`endif
                    end else if (db_cnt_r == DB_LAST) begin
                        scan_cnt_r <= {SCAN_W{1'b0}};
                        cols_r     <= {cols_r[2:0], cols_r[3]};
                        col_idx_r  <= col_idx_r + 2'd1;
                        state_r    <= SCAN;
                    end else begin
                        db_cnt_r <= db_cnt_r + DB_ONE;
                    end
                end
                default: begin
                    scan_cnt_r <= {SCAN_W{1'b0}};
                    cols_r     <= 4'b1110;
                    col_idx_r  <= 2'd0;
                    state_r    <= SCAN;
                end
            endcase
        end
    end

    assign cols      = cols_r;
    assign s0        = s0_r;
    assign s1        = s1_r;
    assign key_valid = key_valid_r;

endmodule

// File: tb/tb_keypad_digit_capture.sv
// Self-checking bench for keypad_digit_capture: directed corner sequences,
// a vector table and randomized presses against a digit-history model.
module tb_keypad_digit_capture;

    localparam int SCAN_DIV = 4;
    localparam int DB_CYC   = 8;
    localparam int REP_CYC  = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       key_valid;
    logic [15:0] pressed = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    int pulse_cnt = 0;
    int cols_bad = 0;
    int double_pulse = 0;
    int pulse_cycle[$];
    logic kv_prev = 1'b0;
    logic [3:0] key_label [4][4];

    typedef struct {
        int         row;
        int         col;
        int         hold;
        int         rel;
        logic [3:0] exp_s0;
        logic [3:0] exp_s1;
        int         exp_pulses;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    keypad_digit_capture #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DB_CYC),
        .REPEAT_CYCLES   (REP_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .s0        (s0),
        .s1        (s1),
        .key_valid (key_valid)
    );

    // Passive keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    always @(negedge clk) begin
        cycle++;
        if (!(cols == 4'b1110 || cols == 4'b1101 || cols == 4'b1011 || cols == 4'b0111)) cols_bad++;
        if (key_valid) begin
            pulse_cnt++;
            pulse_cycle.push_back(cycle);
            if (kv_prev) double_pulse++;
        end
        kv_prev = key_valid;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_col(input logic [3:0] target, output bit found);
        logic [3:0] prev;
        prev = cols;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            tick(1);
            if (cols == target && prev != target) found = 1'b1;
            prev = cols;
        end
    endtask

    task automatic press(input int r, input int c);
        pressed[r*4+c] = 1'b1;
    endtask

    initial begin
        bit found;
        int p0, cyc_p, idx0, kind, r, c, r2, hold, rel;
        logic [3:0] m_s0, m_s1;

        key_label = '{'{4'h1, 4'h2, 4'h3, 4'hA}, '{4'h4, 4'h5, 4'h6, 4'hB},
                      '{4'h7, 4'h8, 4'h9, 4'hC}, '{4'hE, 4'h0, 4'hF, 4'hD}};
        vecs[0] = '{0, 0, 36, 20, 4'h1, 4'h0, 1};
        vecs[1] = '{3, 1, 36, 20, 4'h0, 4'h1, 1};
        vecs[2] = '{3, 3, 36, 20, 4'hD, 4'h0, 1};
        vecs[3] = '{2, 3, 36, 20, 4'hC, 4'hD, 1};
        vecs[4] = '{3, 0, 36, 20, 4'hE, 4'hC, 1};
        vecs[5] = '{1, 2, 36, 20, 4'h6, 4'hE, 1};
        vecs[6] = '{0, 1,  3, 20, 4'h6, 4'hE, 0};

        // Reset state
        tick(3);
        check("rst_s0", s0, 4'h0);
        check("rst_s1", s1, 4'h0);
        check("rst_cols", cols, 4'b1110);
        check("rst_kv", key_valid, 1'b0);

        // Key 5 held from reset release
        press(1, 1);
        reset = 1'b1;
        tick(20);
        check("k5_s0", s0, 4'h5);
        check("k5_s1", s1, 4'h0);
        check("k5_pulses", pulse_cnt, 1);
        check("k5_cols_frozen", cols, 4'b1101);
        pressed = 16'h0000;
        tick(16);

        // Key 9, then a 3-cycle release glitch
        press(2, 2);
        tick(36);
        check("k9_s0", s0, 4'h9);
        check("k9_s1", s1, 4'h5);
        check("k9_pulses", pulse_cnt, 2);
        pressed = 16'h0000;
        tick(3);
        press(2, 2);
        tick(10);
        check("glitch_pulses", pulse_cnt, 2);
        check("glitch_cols", cols, 4'b1011);
        pressed = 16'h0000;
        tick(16);

        // Press bounce of 5 cycles on key 8
        p0 = pulse_cnt;
        wait_col(4'b1101, found);
        check("bounce_col_seen", found, 1'b1);
        press(2, 1);
        tick(5);
        pressed = 16'h0000;
        tick(1);
        check("bounce_cols_frozen", cols, 4'b1101);
        tick(2);
        check("bounce_next_col", cols, 4'b1011);
        tick(16);
        check("bounce_s0", s0, 4'h9);
        check("bounce_s1", s1, 4'h5);
        check("bounce_pulses", pulse_cnt, p0);

        // Two rows low in one column, then a second key during HELD
        press(1, 0);
        press(2, 0);
        tick(36);
        check("dual_pulses", pulse_cnt, p0);
        check("dual_s0", s0, 4'h9);
        pressed = 16'h0000;
        tick(16);
        press(0, 3);
        tick(30);
        press(1, 3);
        tick(6);
        check("second_key_s0", s0, 4'hA);
        check("second_key_s1", s1, 4'h9);
        check("second_key_pulses", pulse_cnt, p0 + 1);
        pressed = 16'h0000;
        tick(16);

        // Reset in the middle of press debounce
        p0 = pulse_cnt;
        wait_col(4'b0111, found);
        check("mid_db_col_seen", found, 1'b1);
        press(0, 0);
        press(0, 3);
        tick(7);
        check("mid_db_frozen", cols, 4'b0111);
        reset = 1'b0;
        #1;
        check("mid_rst_s0", s0, 4'h0);
        check("mid_rst_s1", s1, 4'h0);
        check("mid_rst_cols", cols, 4'b1110);
        check("mid_rst_kv", key_valid, 1'b0);
        tick(3);
        pressed = 16'h0000;
        tick(2);
        reset = 1'b1;
        tick(30);
        check("post_rst_pulses", pulse_cnt, p0);
        check("post_rst_s0", s0, 4'h0);

        // Vector table
        foreach (vecs[i]) begin
            p0 = pulse_cnt;
            press(vecs[i].row, vecs[i].col);
            tick(vecs[i].hold);
            pressed = 16'h0000;
            tick(vecs[i].rel);
            check($sformatf("vec%0d_s0", i), s0, vecs[i].exp_s0);
            check($sformatf("vec%0d_s1", i), s1, vecs[i].exp_s1);
            check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_pulses);
        end

        // Randomized presses against a digit-history model
        m_s0 = 4'h6;
        m_s1 = 4'hE;
        for (int i = 0; i < 16; i++) begin
            kind = $urandom_range(0, 2);
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            rel = $urandom_range(14, 24);
            hold = (kind == 1) ? $urandom_range(1, 5) : $urandom_range(28, 36);
            p0 = pulse_cnt;
            press(r, c);
            if (kind == 2) begin
                r2 = (r + 1 + $urandom_range(0, 2)) % 4;
                press(r2, c);
            end
            tick(hold);
            pressed = 16'h0000;
            tick(rel);
            if (kind == 0) begin
                m_s1 = m_s0;
                m_s0 = key_label[r][c];
            end
            check($sformatf("rnd%0d_s0", i), s0, m_s0);
            check($sformatf("rnd%0d_s1", i), s1, m_s1);
            check($sformatf("rnd%0d_pulses", i), pulse_cnt - p0, (kind == 0) ? 1 : 0);
        end

        // Long hold of A: one pulse, or three 32 cycles apart with auto-repeat
        p0 = pulse_cnt;
        idx0 = pulse_cycle.size();
        wait_col(4'b0111, found);
        check("hold_col_seen", found, 1'b1);
        cyc_p = cycle;
        press(0, 3);
        tick(100);
        pressed = 16'h0000;
        tick(16);
        check("hold_s0", s0, 4'hA);
        if (pulse_cycle.size() > idx0) check("hold_first_pulse", pulse_cycle[idx0] - cyc_p, 12);
        else check("hold_first_pulse_seen", pulse_cycle.size() - idx0, 1);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("rep_pulses", pulse_cnt - p0, 3);
        check("rep_s1", s1, 4'hA);
        if (pulse_cycle.size() >= idx0 + 3) begin
            check("rep_gap1", pulse_cycle[idx0+1] - pulse_cycle[idx0], REP_CYC);
            check("rep_gap2", pulse_cycle[idx0+2] - pulse_cycle[idx0+1], REP_CYC);
        end
`else
        check("norep_pulses", pulse_cnt - p0, 1);
        check("norep_s1", s1, m_s0);
`endif

        check("cols_one_low", cols_bad, 0);
        check("kv_single_cycle", double_pulse, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_digit_capture.md
KEYPAD_DIGIT_CAPTURE -- requirements
Module: keypad_digit_capture

Interface
REQ-001 Parameter SCAN_DIV, default 24000, SHALL set the clk cycles each column is driven (1 ms at 24 MHz).
REQ-002 Parameter DEBOUNCE_CYCLES, default 480000, SHALL set the consecutive stable cycles required for press and release (20 ms).
REQ-003 Parameter REPEAT_CYCLES, default 12000000, SHALL set the auto-repeat period (0.5 s); it is used only with KEYPAD_AUTOREPEAT_EN.
REQ-004 clk  input  1  SHALL be the system clock.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 rows  input  4  SHALL carry the keypad row lines: active-low, externally pulled up, asynchronous to clk.
REQ-007 cols  output  4  SHALL drive the keypad columns active-low, with exactly one bit low at all times.
REQ-008 s0  output  4  SHALL hold the most recent digit, and SHALL feed the display stage's first digit.
REQ-009 s1  output  4  SHALL hold the previous digit, and SHALL feed the display stage's second digit.
REQ-010 key_valid  output  1  SHALL pulse high for one cycle on each accepted key.

Function
REQ-011 rows SHALL pass through a 2-flop synchronizer (rows_s) before any use; FSM latency from a pin change is 2 cycles.
REQ-012 The FSM SHALL have exactly the states SCAN, PRESS_DB, HELD and RELEASE_DB.
REQ-013 In SCAN, the low column SHALL rotate col0->col1->col2->col3->col0 every SCAN_DIV cycles.
REQ-014 In SCAN, rows_s SHALL be sampled only on the last cycle of each column dwell.
REQ-015 A sample with exactly one row low SHALL capture (row, col), freeze cols, clear the counter and enter PRESS_DB.
REQ-016 A sample with zero rows low, or with two or more rows low, SHALL be ignored and rotation SHALL continue.
REQ-017 In PRESS_DB, any cycle in which rows_s differs from the captured pattern SHALL return to SCAN, advancing to the next column.
REQ-018 In PRESS_DB, after DEBOUNCE_CYCLES consecutive matching cycles, the block SHALL enter HELD.
REQ-019 On entry to HELD, the block SHALL do the following in the same cycle: s1<=s0; s0<=decoded digit; key_valid=1.
REQ-020 The decode SHALL map row0 cols0-3 to 1,2,3,A; row1 to 4,5,6,B; row2 to 7,8,9,C; row3 to E,0,F,D.
REQ-021 In HELD, cols SHALL stay frozen and additional keys SHALL be ignored; when rows_s==4'hF, the block SHALL clear the counter and enter RELEASE_DB.
REQ-022 In RELEASE_DB, any low row SHALL return to HELD.
REQ-023 In RELEASE_DB, DEBOUNCE_CYCLES consecutive cycles of all-high SHALL return to SCAN with the next column.
REQ-024 key_valid SHALL be 0 in all cycles except the HELD-entry cycle (and the repeat cycles of REQ-029).
REQ-025 Counters SHALL be sized with $clog2 of their maximum parameter value, and SHALL not wrap before their terminal count.

Reset
REQ-026 While reset==0, the block SHALL hold: state=SCAN, cols=4'b1110, s0=s1=4'h0, key_valid=0, all counters and synchronizer flops = 0/idle (synchronizer flops = 1).
REQ-027 Reset asserted in any state (including mid-debounce) SHALL discard the captured key and SHALL not alter s0/s1 except to clear them.

Configuration
REQ-028 Macro KEYPAD_AUTOREPEAT_EN SHALL control auto-repeat: when undefined, HELD SHALL produce no further key_valid pulses.
REQ-029 When KEYPAD_AUTOREPEAT_EN is defined, each REPEAT_CYCLES cycles continuously in HELD SHALL repeat the REQ-019 shift and pulse key_valid; the repeat counter SHALL restart on every HELD entry.

Structure
REQ-030 Package keypad_pkg SHALL hold the state enum, the 16-entry row/col-to-hex decode table and the default timing constants.
REQ-031 Sub-module keypad_sync2 (4-bit 2-flop synchronizer) SHALL be instantiated once; all other logic SHALL be flat.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32)
REQ-032 Bench SHALL cover: after reset, hold key 5 (row1 at col1) for 20 cycles -> s0=5, s1=0, one key_valid pulse, cols frozen at 4'b1101.
REQ-033 Bench SHALL cover: then release, press 9 -> s0=9, s1=5; release glitch of 3 cycles -> no extra pulse.
REQ-034 Bench SHALL cover: press bounce of 5 cycles then release -> s0/s1 unchanged, key_valid never high, scan resumes at next column.
REQ-035 Bench SHALL cover: rows1 and 2 low in same column -> ignored; key held while a second key pressed -> only the first digit accepted.
REQ-036 Bench SHALL cover: reset asserted in PRESS_DB cycle 4 -> s0=s1=0, cols=4'b1110, no pulse.
REQ-037 Bench SHALL cover: with KEYPAD_AUTOREPEAT_EN, hold A for 100 cycles -> pulses at HELD entry +32 and +64 (3 total), final s0=A, s1=A.
